// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC select, IF/ID register,
// stall/flush handling and saturating fetch/flush performance counters.
module pc_fetch_unit #(
  parameter int unsigned          PC_W      = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    reg_target,
  input  logic               stall,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               redirect,
  output logic [15:0]        fetch_count,
  output logic [15:0]        flush_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_JUMP   = 2'b01,
    SRC_BRANCH = 2'b10,
    SRC_REG    = 2'b11
  } pc_src_e;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    target;
  logic               redirect_c;

  // Target select; a bubble in IF/ID never redirects
  always_comb begin
    pc_plus1   = pc_q + PC_W'(1);
    redirect_c = valid_q & ~stall & (pc_src != SRC_SEQ);
    target     = pc_plus1;
    case (pc_src_e'(pc_src))
      SRC_JUMP:   target = jump_target;
      SRC_BRANCH: target = branch_target;
      SRC_REG:    target = reg_target;
      default:    target = pc_plus1;
    endcase
  end

  // Next-state: stall holds, redirect flushes, otherwise fetch sequentially
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc1_d       = pc1_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!stall) begin
      if (redirect_c) begin
        pc_d    = target;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        pc_d    = pc_plus1;
        instr_d = imem_instr;
        pc1_d   = pc_plus1;
        valid_d = 1'b1;
        if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc1_q       <= '0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc1_q       <= pc1_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus1 = pc1_q;
  assign if_id_valid    = valid_q;
  assign redirect       = redirect_c;
  assign fetch_count    = fetch_cnt_q;
  assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed plan items plus random
// stimulus against a cycle-level reference model of the fetch stage.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_src;
  logic [15:0] jump_target, branch_target, reg_target;
  logic        stall;
  logic [15:0] imem_instr;
  logic [15:0] imem_addr, if_id_instr, if_id_pc_plus1;
  logic        if_id_valid, redirect;
  logic [15:0] fetch_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_pc1, m_fetch, m_flush;
  logic        m_valid;

  always #5 clk = ~clk;

  // Zero-wait instruction memory: word = addr ^ A000
  assign imem_instr = imem_addr ^ 16'hA000;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .jump_target    (jump_target),
    .branch_target  (branch_target),
    .reg_target     (reg_target),
    .stall          (stall),
    .imem_instr     (imem_instr),
    .imem_addr      (imem_addr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .redirect       (redirect),
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Apply one rule-level step of the fetch stage to the model
  task automatic model_edge();
    logic [15:0] tgt;
    if (reset) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pc1 = 16'h0000;
      m_valid = 1'b0; m_fetch = 16'h0000; m_flush = 16'h0000;
    end else if (stall) begin
      // everything holds
    end else if (m_valid && pc_src != 2'b00) begin
      tgt = (pc_src == 2'b01) ? jump_target :
            (pc_src == 2'b10) ? branch_target : reg_target;
      m_pc = tgt; m_instr = 16'h0000; m_valid = 1'b0;
      m_flush = sat_inc(m_flush);
    end else begin
      m_instr = m_pc ^ 16'hA000;
      m_pc    = m_pc + 16'd1;
      m_pc1   = m_pc;
      m_valid = 1'b1;
      m_fetch = sat_inc(m_fetch);
    end
  endtask

  task automatic check_state();
    check("pc", 32'(imem_addr), 32'(m_pc));
    check("valid", 32'(if_id_valid), 32'(m_valid));
    check("instr", 32'(if_id_instr), 32'(m_instr));
    if (m_valid) check("pc_plus1", 32'(if_id_pc_plus1), 32'(m_pc1));
    check("fetch_count", 32'(fetch_count), 32'(m_fetch));
    check("flush_count", 32'(flush_count), 32'(m_flush));
  endtask

  // One clock: check combinational redirect, take edge, compare registers
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) check("redirect", 32'(redirect), 32'(m_valid & ~stall & (pc_src != 2'b00)));
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) check_state();
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [1:0] src);
    reset = rst; stall = stl; pc_src = src;
  endtask

  initial begin
    jump_target = 16'h0; branch_target = 16'h0; reg_target = 16'h0;
    m_pc = '0; m_instr = '0; m_pc1 = '0; m_valid = 1'b0; m_fetch = '0; m_flush = '0;
    drive(1'b1, 1'b0, 2'b00);
    step(1'b1);
    check("rst_pc", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);

    // Free run from reset
    drive(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("run_pc", 32'(imem_addr), 32'h0004);
    check("run_instr", 32'(if_id_instr), 32'hA003);
    check("run_pc1", 32'(if_id_pc_plus1), 32'h0004);
    check("run_fetch", 32'(fetch_count), 32'd4);
    step(1'b1);

    // Branch taken at pc=0005
    check("br_start_pc", 32'(imem_addr), 32'h0005);
    branch_target = 16'h0020; drive(1'b0, 1'b0, 2'b10);
    step(1'b1);
    check("br_pc", 32'(imem_addr), 32'h0020);
    check("br_bubble", 32'(if_id_valid), 32'h0);
    check("br_flush", 32'(flush_count), 32'd1);
    drive(1'b0, 1'b0, 2'b00);
    step(1'b1);
    check("br_tgt_instr", 32'(if_id_instr), 32'hA020);
    check("br_tgt_pc1", 32'(if_id_pc_plus1), 32'h0021);

    // Jump, then register return
    jump_target = 16'h0100; drive(1'b0, 1'b0, 2'b01);
    step(1'b1);
    check("jmp_pc", 32'(imem_addr), 32'h0100);
    drive(1'b0, 1'b0, 2'b00);
    step(1'b1);
    reg_target = 16'h0042; drive(1'b0, 1'b0, 2'b11);
    step(1'b1);
    check("jr_pc", 32'(imem_addr), 32'h0042);
    check("jr_flush", 32'(flush_count), 32'd3);
    drive(1'b0, 1'b0, 2'b00);
    step(1'b1);

    // Stall blocks a pending branch, which is taken once stall drops
    branch_target = 16'h0300; drive(1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 3; i++) step(1'b1);
    drive(1'b0, 1'b0, 2'b10);
    #1 check("stall_release_redirect", 32'(redirect), 32'h1);
    step(1'b1);
    check("stall_br_pc", 32'(imem_addr), 32'h0300);

    // Bubble in IF/ID: pc_src ignored
    jump_target = 16'h0777; drive(1'b0, 1'b0, 2'b01);
    #1 check("bubble_no_redirect", 32'(redirect), 32'h0);
    step(1'b1);
    check("bubble_pc", 32'(imem_addr), 32'h0301);

    // Wrap: jump to FFFF, sequential fetch wraps to 0000
    jump_target = 16'hFFFF;
    step(1'b1);
    check("wrap_jmp_pc", 32'(imem_addr), 32'hFFFF);
    drive(1'b0, 1'b0, 2'b00);
    step(1'b1);
    check("wrap_pc", 32'(imem_addr), 32'h0000);
    check("wrap_pc1", 32'(if_id_pc_plus1), 32'h0000);

    // Reset during stall and redirect request
    drive(1'b1, 1'b1, 2'b10);
    step(1'b1);
    check("mid_rst_fetch", 32'(fetch_count), 32'h0);
    check("mid_rst_instr", 32'(if_id_instr), 32'h0);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      jump_target   = 16'($urandom);
      branch_target = 16'($urandom);
      reg_target    = 16'($urandom);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
      step(1'b1);
    end

    // Saturation of fetch_count
    drive(1'b1, 1'b0, 2'b00);
    step(1'b1);
    drive(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 70000; i++) step(1'b0);
    check_state();
    check("sat_fetch", 32'(fetch_count), 32'hFFFF);
    step(1'b1);
    check("sat_hold", 32'(fetch_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
